// File: rtl/regfile_pkg.sv
// Shared register-file types and default geometry, used by the regfile
// and by the write-back arbiter that feeds its single write port.
package regfile_pkg;

    localparam int NUMREGS_DEF   = 32;
    localparam int DATAWIDTH_DEF = 32;
    localparam int ADDRW_DEF     = $clog2(NUMREGS_DEF);

    // One write-back request as presented by a requester
    typedef struct packed {
        logic [ADDRW_DEF-1:0]     addr;
        logic [DATAWIDTH_DEF-1:0] data;
    } wb_req_t;

    // What the regfile write port sees
    typedef struct packed {
        logic                     we;
        logic [ADDRW_DEF-1:0]     addr;
        logic [DATAWIDTH_DEF-1:0] data;
    } wb_port_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the write-back requesters and the arbiter, plus the
// regfile write port, pending mask and contention counter it drives.
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NUMREQ    = 3,
    parameter int NUMREGS   = NUMREGS_DEF,
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int ADDRW     = $clog2(NUMREGS),
    parameter int CNTW      = 16
) ();

    logic                          hold_i;
    logic [NUMREQ-1:0]             req_valid_i;
    logic [NUMREQ-1:0]             req_ready_o;
    logic [NUMREQ*ADDRW-1:0]       req_addr_i;
    logic [NUMREQ*DATAWIDTH-1:0]   req_data_i;
    logic                          we_o;
    logic [ADDRW-1:0]              waddr_o;
    logic [DATAWIDTH-1:0]          wdata_o;
    logic [NUMREGS-1:0]            pending_o;
    logic [CNTW-1:0]               conflict_cnt_o;

    // Requester / pipeline side
    modport master (
        output hold_i, req_valid_i, req_addr_i, req_data_i,
        input  req_ready_o, we_o, waddr_o, wdata_o, pending_o, conflict_cnt_o
    );

    // Arbiter side
    modport slave (
        input  hold_i, req_valid_i, req_addr_i, req_data_i,
        output req_ready_o, we_o, waddr_o, wdata_o, pending_o, conflict_cnt_o
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: rotating priority pointer, one grant per cycle,
// pointer moves just past the winner so every requester gets its turn.
module rr_arbiter #(
    parameter int N    = 3,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_i,
    input  logic            hold_i,
    output logic [N-1:0]    grant_o,
    output logic [IDXW-1:0] grant_idx_o,
    output logic            grant_valid_o
);

    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] ptr_d;
    logic [IDXW:0]   cand;

    // Scan ptr, ptr+1, ... with wrap and grant the first valid requester
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        cand          = '0;
        for (int i = 0; i < N; i++) begin
            cand = (IDXW+1)'(ptr_q) + (IDXW+1)'(i);
            if (cand >= (IDXW+1)'(N)) begin
                cand = cand - (IDXW+1)'(N);
            end
            if (!hold_i && !grant_valid_o && req_i[cand[IDXW-1:0]]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = cand[IDXW-1:0];
            end
        end
        if (grant_valid_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

    // Move the pointer one past the winner, wrapping at N-1; hold otherwise
    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid_o) begin
            ptr_d = (grant_idx_o == IDXW'(N - 1)) ? '0 : grant_idx_o + IDXW'(1);
        end
    end

    // Priority pointer register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: picks one requester per cycle, stages the winning
// write for one cycle, drops writes to x0, and reports pending writes and
// how often requesters collided.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUMREQ    = 3,
    parameter int NUMREGS   = NUMREGS_DEF,
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int ADDRW     = $clog2(NUMREGS),
    parameter int CNTW      = 16
) (
    input logic                 clk_i,
    input logic                 rst_i,
    regfile_wb_arbiter_if.slave bus
);

    localparam int IDXW = (NUMREQ > 1) ? $clog2(NUMREQ) : 1;

    logic [NUMREQ-1:0]    grant;
    logic [IDXW-1:0]      grant_idx;
    logic                 grant_valid;
    logic [ADDRW-1:0]     grant_addr;
    logic [DATAWIDTH-1:0] grant_data;

    logic                 we_q,      we_d;
    logic [ADDRW-1:0]     waddr_q,   waddr_d;
    logic [DATAWIDTH-1:0] wdata_q,   wdata_d;
    logic [NUMREGS-1:0]   pending_q, pending_d;
    logic [CNTW-1:0]      cnt_q,     cnt_d;

    rr_arbiter #(
        .N    (NUMREQ),
        .IDXW (IDXW)
    ) u_rr_arbiter (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (bus.req_valid_i),
        .hold_i        (bus.hold_i),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    // Select the winner's address and data out of the packed request buses
    always_comb begin
        grant_addr = bus.req_addr_i[grant_idx*ADDRW +: ADDRW];
        grant_data = bus.req_data_i[grant_idx*DATAWIDTH +: DATAWIDTH];
    end

    // Next output stage: x0 writes are accepted but never enable the port
    always_comb begin
        we_d      = grant_valid && (grant_addr != '0);
        waddr_d   = grant_valid ? grant_addr : waddr_q;
        wdata_d   = grant_valid ? grant_data : wdata_q;
        pending_d = '0;
        for (int k = 0; k < NUMREGS; k++) begin
            pending_d[k] = we_d && (grant_addr == ADDRW'(k));
        end
    end

    // Count cycles where two or more requesters compete, saturating at max
    always_comb begin
        cnt_d = cnt_q;
        if (!bus.hold_i && ($countones(bus.req_valid_i) >= 2) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    // Output stage and counter registers; reset discards any staged write
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.req_ready_o    = grant;
    assign bus.we_o           = we_q;
    assign bus.waddr_o        = waddr_q;
    assign bus.wdata_o        = wdata_q;
    assign bus.pending_o      = pending_q;
    assign bus.conflict_cnt_o = cnt_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between NUMREQ write-back requesters, such as the ALU, the load unit and the CSR unit. Each requester uses a valid/ready handshake. A round-robin arbiter with a rotating priority pointer picks one requester per cycle, and the winning write is registered once before it drives the regfile write port. The block also drives a pending-write mask for forwarding/hazard logic, and a saturating contention counter for performance monitoring.

Parameters:
NUMREQ, 3, number of write-back requesters (2..8)
NUMREGS, 32, number of architectural registers
DATAWIDTH, 32, write data width
ADDRW, $clog2(NUMREGS), register address width
CNTW, 16, contention counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
hold_i  in  1  stall arbitration; no grant issued while high
req_valid_i  in  NUMREQ  per-requester write request valid
req_ready_o  out  NUMREQ  per-requester accept, one-hot or zero
req_addr_i  in  NUMREQ*ADDRW  packed destination addresses; requester i at [i*ADDRW +: ADDRW]
req_data_i  in  NUMREQ*DATAWIDTH  packed write data; requester i at [i*DATAWIDTH +: DATAWIDTH]
we_o  out  1  regfile write enable
waddr_o  out  ADDRW  regfile write address
wdata_o  out  DATAWIDTH  regfile write data
pending_o  out  NUMREGS  one-hot of waddr_o when we_o=1, else 0
conflict_cnt_o  out  CNTW  saturating count of cycles with >1 valid requester while not held

Behaviour:
- Reset values: we_o=0, waddr_o=0, wdata_o=0, pending_o=0, conflict_cnt_o=0, priority pointer=0.
- Reset is asynchronous. Asserting it mid-operation discards any staged write, so we_o drops immediately.
- Handshake: a transfer on requester i occurs when req_valid_i[i] & req_ready_o[i].
  - Requesters hold valid, addr and data stable until accepted.
  - The block never retracts ready once valid is seen in that cycle.
- req_ready_o is combinational from req_valid_i, the pointer and hold_i.
  - If hold_i=1 or no request is valid, req_ready_o=0.
  - Otherwise exactly one bit is set: the first valid index found scanning from ptr, ptr+1, ... with wrap at NUMREQ-1 -> 0.
- Pointer update, on a registered edge when a grant occurs to g: ptr <= (g==NUMREQ-1) ? 0 : g+1. With no grant, ptr holds.
- Latency: grant in cycle N -> we_o/waddr_o/wdata_o valid in cycle N+1, for exactly one cycle unless another grant occurs in N+1. Back-to-back grants give we_o=1 continuously. Throughput is one write per cycle.
- The output stage never back-pressures, because the regfile write port always accepts.
- Writes to register 0:
  - They are granted normally (ready=1) and advance the pointer.
  - They do not assert we_o, and pending_o stays 0.
  - waddr_o/wdata_o may update, but are don't-care while we_o=0.
- No grant in cycle N -> we_o=0 in N+1. waddr_o/wdata_o hold their last values.
- hold_i=1: no grant, pointer frozen, and conflict_cnt_o is not incremented. The staged write from the previous cycle still commits.
- conflict_cnt_o increments by 1 on each cycle with hold_i=0 and popcount(req_valid_i)>=2. It saturates at all-ones with no wrap.
- pending_o[k]=1 iff we_o=1 and waddr_o==k. It is a registered output, aligned with we_o.
- Two requesters targeting the same address in consecutive grants commit in grant order, so the later one wins in the regfile.
- Fairness: a continuously valid requester is granted within NUMREQ grant cycles (with hold_i=0).

Decomposition:
- Package regfile_pkg holds the following, which regfile and this block share:
  - constants NUMREGS_DEF=32, DATAWIDTH_DEF=32, ADDRW_DEF
  - typedef wb_req_t {addr, data}
  - typedef wb_port_t {we, addr, data}
- Sub-module rr_arbiter:
  - parameter N
  - inputs: req vector, hold, clk/rst
  - outputs: one-hot grant and grant index
  - owns the pointer register and wrap logic
- The top level owns the output register, the x0 filter, pending decode and the contention counter.

Test Plan:
- Reset, then req_valid_i=3'b111 for 6 cycles with addrs 5/6/7 -> grants in order 0,1,2,0,1,2. we_o=1 from cycle 2 on, waddr_o sequence 5,6,7,5,6,7. conflict_cnt_o=6.
- A single requester 1 with addr=10, data=0xDEADBEEF for one cycle -> req_ready_o=3'b010. Next cycle: we_o=1, waddr_o=10, wdata_o=0xDEADBEEF, pending_o=1<<10. The cycle after: we_o=0, pending_o=0.
- Requester 0 with addr=0 and data=0x1234 -> ready=1 and pointer advances to 1. we_o stays 0 and pending_o=0.
- With hold_i=1 for 3 cycles and all requesters valid -> req_ready_o=0, conflict_cnt_o unchanged, pointer unchanged. After release, the first grant goes to the pre-hold pointer index.
- With CNTW=2 and all requesters valid for 5 cycles -> conflict_cnt_o reads 1,2,3,3,3 (saturates).
- Assert rst_i asynchronously mid-cycle while we_o=1 -> we_o, pending_o and conflict_cnt_o go to 0 immediately. After release, the first grant goes to requester 0.
